// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// the default operand width.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_subtractor.sv
// WIDTH-bit subtractor a-b computed as a + ~b + 1; borrow is the inverted
// carry out of the adder.
module seq_divider_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH:0] sum;

  assign sum    = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
  assign diff   = sum[WIDTH-1:0];
  assign borrow = ~sum[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, with signed
// operands handled by dividing magnitudes and fixing signs at the end.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t           state;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CNT_W-1:0] counter;
  logic             qneg;
  logic             rneg;
  logic             zero_flag;

  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] p_shift;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             take;
  logic [WIDTH-1:0] q_neg;
  logic [WIDTH-1:0] p_neg;

  assign sa           = signed_op & dividend[WIDTH-1];
  assign sb           = signed_op & divisor[WIDTH-1];
  assign dividend_mag = sa ? (~dividend + WIDTH'(1)) : dividend;
  assign divisor_mag  = sb ? (~divisor + WIDTH'(1)) : divisor;
  assign q_neg        = ~q + WIDTH'(1);
  assign p_neg        = ~p + WIDTH'(1);

  assign p_shift = {p[WIDTH-2:0], q[WIDTH-1]};

  seq_divider_subtractor #(.WIDTH(WIDTH)) u_sub (
    .a      (p_shift),
    .b      (d),
    .diff   (diff),
    .borrow (borrow)
  );

  // A set top bit of P means the shifted value exceeds WIDTH bits and is
  // therefore larger than any divisor, so the subtraction must be taken.
  assign take = ~borrow | p[WIDTH-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      counter     <= '0;
      p           <= '0;
      q           <= '0;
      d           <= '0;
      qneg        <= 1'b0;
      rneg        <= 1'b0;
      zero_flag   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !done) begin
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              q         <= dividend;
              zero_flag <= 1'b1;
              state     <= S_FIX;
            end else begin
              zero_flag <= 1'b0;
              p         <= '0;
              q         <= dividend_mag;
              d         <= divisor_mag;
              qneg      <= sa ^ sb;
              rneg      <= sa;
              counter   <= CNT_W'(WIDTH);
              busy      <= 1'b1;
              state     <= S_CALC;
            end
          end
        end
        S_CALC: begin
          q       <= {q[WIDTH-2:0], take};
          p       <= take ? diff : p_shift;
          counter <= counter - CNT_W'(1);
          if (counter == CNT_W'(1)) begin
            busy  <= 1'b0;
            state <= S_FIX;
          end
        end
        S_FIX: begin
          done  <= 1'b1;
          state <= S_IDLE;
          if (zero_flag) begin
            quotient    <= '1;
            remainder   <= q;
            div_by_zero <= 1'b1;
          end else begin
            quotient  <= qneg ? q_neg : q;
            remainder <= rneg ? p_neg : p;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases followed by
// randomized operations compared against an arithmetic reference model.
module tb_seq_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int tests;
  int failures;

  seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division, truncating toward zero when signed
  function automatic void refDiv(input logic sop, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] eq,
                                 output logic [31:0] er, output logic ez);
    longint sa;
    longint sb;
    ez = (b == 32'd0);
    if (b == 32'd0) begin
      eq = 32'hFFFF_FFFF;
      er = a;
    end else if (sop) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      eq = 32'(sa / sb);
      er = 32'(sa % sb);
    end else begin
      eq = a / b;
      er = a % b;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Issues one divide from a falling edge and follows it to its done pulse.
  // hold: cycles start stays high; poke_at: cycle at which a stray start is
  // pulsed mid-operation (0 = none).
  task automatic applyStimulus(input logic sop, input logic [31:0] a,
                               input logic [31:0] b, input int gap,
                               input int hold, input int poke_at,
                               input string tag);
    logic [31:0] eq;
    logic [31:0] er;
    logic        ez;
    int          k;
    int          busy_cnt;
    logic        saw_both;
    int          exp_lat;
    repeat (gap) @(negedge clk);
    signed_op = sop;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    k         = 0;
    busy_cnt  = 0;
    saw_both  = 1'b0;
    while (k < 100) begin
      @(negedge clk);
      k++;
      if (k == hold) start = 1'b0;
      if (poke_at != 0 && k == poke_at) begin
        start    = 1'b1;
        dividend = ~a;
        divisor  = b + 32'd1;
      end
      if (poke_at != 0 && k == poke_at + 1) start = 1'b0;
      if (busy && done) saw_both = 1'b1;
      if (done) break;
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    refDiv(sop, a, b, eq, er, ez);
    exp_lat = ((b == 32'd0) ? 2 : 34) + hold - 1;
    checkOutput({tag, " latency"}, 32'(k), 32'(exp_lat));
    checkOutput({tag, " busy_cycles"}, 32'(busy_cnt), (b == 32'd0) ? 32'd0 : 32'd32);
    checkOutput({tag, " busy_and_done"}, {31'd0, saw_both}, 32'd0);
    checkOutput({tag, " quotient"}, quotient, eq);
    checkOutput({tag, " remainder"}, remainder, er);
    checkOutput({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, ez});
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, " busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, " done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, " quotient"}, quotient, 32'd0);
    checkOutput({tag, " remainder"}, remainder, 32'd0);
    checkOutput({tag, " div_by_zero"}, {31'd0, div_by_zero}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic        saw_done;
    tests     = 0;
    failures  = 0;
    reset     = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    repeat (3) @(negedge clk);
    checkIdleZero("reset");
    reset = 1'b0;

    applyStimulus(1'b0, 32'd100, 32'd7, 1, 1, 0, "u100_7");
    applyStimulus(1'b1, -32'sd100, 32'd7, 1, 1, 0, "s-100_7");
    applyStimulus(1'b1, 32'd100, -32'sd7, 1, 1, 0, "s100_-7");
    applyStimulus(1'b0, 32'h0000_1234, 32'd0, 1, 1, 0, "divzero");
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1, 0, "s_overflow");
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, 1, 1, 0, "u_max_1");
    applyStimulus(1'b1, 32'hFFFF_8000, 32'd0, 1, 1, 0, "s_divzero");
    applyStimulus(1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1, 1, 0, "u_big_div");
    applyStimulus(1'b0, 32'd1000, 32'd33, 1, 1, 10, "ignore_mid");
    applyStimulus(1'b1, -32'sd77, -32'sd5, 0, 2, 0, "back2back");

    // Reset in the middle of the iteration
    @(negedge clk);
    signed_op = 1'b0;
    dividend  = 32'd5000;
    divisor   = 32'd3;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkIdleZero("midreset");
    reset    = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checkOutput("midreset no_done", {31'd0, saw_done}, 32'd0);
    applyStimulus(1'b0, 32'd5000, 32'd3, 1, 1, 0, "after_reset");

    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'($urandom_range(1, 15));
        1: rb = $urandom;
        2: rb = 32'd0;
        3: rb = -32'($urandom_range(1, 300));
        4: rb = $urandom | 32'h8000_0000;
        default: begin
          rb = $urandom;
          ra = rb >> $urandom_range(1, 8);
        end
      endcase
      applyStimulus(rs, ra, rb, $urandom_range(1, 3), 1, 0, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
